hsid_x_obi_resp_mem: RTL and testbench

OBI responder (slave) memory for the HSID-X subsystem. It answers the OBI read requests issued by the HSID-X OBI master, which fetches captured and library pixel words. It is the memory-side end of the same protocol and is used for block-level and integration benches. It provides a word-organised array with byte-enabled writes, a fixed response latency, optional grant throttling and a backdoor preload port.

---
 rtl/hsid_pkg.sv | 9 +
 rtl/hsid_x_obi_inf_pkg.sv | 26 ++
 rtl/hsid_x_obi_resp_mem_pkg.sv | 16 +
 rtl/hsid_x_obi_resp_mem_if.sv | 15 +
 rtl/hsid_x_obi_rsp_pipe.sv | 39 +++
 rtl/hsid_x_obi_resp_mem.sv | 167 ++++++++++++++++
 tb/tb_hsid_x_obi_resp_mem.sv | 284 ++++++++++++++++++++++++++++
 7 files changed

// File: rtl/hsid_pkg.sv
// hsid_pkg
// Subsystem-wide constants for HSID-X: the pixel word width and the deepest
// response latency the OBI responder memory may be configured with.
package hsid_pkg;

  localparam int unsigned HSID_WORD_WIDTH          = 32;
  localparam int unsigned HSID_OBI_MAX_RSP_LATENCY = 8;

endpackage

// File: rtl/hsid_x_obi_inf_pkg.sv
// hsid_x_obi_inf_pkg
// OBI request/response structs shared by the HSID-X OBI master and the
// responder memory.
//   obi_req_t  : req, we, be (byte enables), addr (byte address), wdata
//   obi_resp_t : gnt, rvalid, rdata
package hsid_x_obi_inf_pkg;
  import hsid_pkg::*;

  localparam int unsigned OBI_ADDR_WIDTH = 32;
  localparam int unsigned OBI_BE_WIDTH   = HSID_WORD_WIDTH / 8;

  typedef struct packed {
    logic                       req;
    logic                       we;
    logic [OBI_BE_WIDTH-1:0]    be;
    logic [OBI_ADDR_WIDTH-1:0]  addr;
    logic [HSID_WORD_WIDTH-1:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic                       gnt;
    logic                       rvalid;
    logic [HSID_WORD_WIDTH-1:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/hsid_x_obi_resp_mem_pkg.sv
// hsid_x_obi_resp_mem_pkg
// Types and helpers local to the OBI responder memory: grant FSM state
// encoding and the width helper for the stall counter.
package hsid_x_obi_resp_mem_pkg;

  typedef enum logic [0:0] {
    GRANT = 1'b0,
    STALL = 1'b1
  } grant_state_e;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/hsid_x_obi_resp_mem_if.sv
// hsid_x_obi_resp_mem_if
// OBI bus bundle between the HSID-X OBI master and the responder memory.
//   obi_req : request struct, driven by the master
//   obi_rsp : response struct, driven by the responder
// Modports: master (drives obi_req), slave (drives obi_rsp).
interface hsid_x_obi_resp_mem_if;
  import hsid_x_obi_inf_pkg::*;

  obi_req_t  obi_req;
  obi_resp_t obi_rsp;

  modport master (output obi_req, input  obi_rsp);
  modport slave  (input  obi_req, output obi_rsp);

endinterface

// File: rtl/hsid_x_obi_rsp_pipe.sv
// hsid_x_obi_rsp_pipe
// Fixed-latency valid/data delay line used to time OBI responses.
// Ports:
//   clk, rst         : clock, asynchronous active-high reset (flushes all stages)
//   valid_i, data_i  : response entering the line at the acceptance edge
//   valid_o, data_o  : response emerging LATENCY edges later
module hsid_x_obi_rsp_pipe #(
  parameter int unsigned LATENCY = 1,
  parameter int unsigned WIDTH   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic [LATENCY-1:0]            valid_q;
  logic [LATENCY-1:0][WIDTH-1:0] data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q[0] <= valid_i;
      data_q[0]  <= data_i;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[LATENCY-1];
  assign data_o  = data_q[LATENCY-1];

endmodule

// File: rtl/hsid_x_obi_resp_mem.sv
// hsid_x_obi_resp_mem
// OBI responder memory for HSID-X benches: word array with byte-enabled
// writes, fixed response latency, optional grant throttling and a backdoor
// preload port.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   obi        : OBI slave bundle (request in, response out)
//   bd_we      : backdoor full-word write strobe
//   bd_addr    : backdoor word index
//   bd_wdata   : backdoor write data
//   addr_err   : one-cycle pulse after an out-of-range request is accepted
//   err_count  : saturating count of out-of-range accepts
module hsid_x_obi_resp_mem
  import hsid_pkg::*;
  import hsid_x_obi_inf_pkg::*;
  import hsid_x_obi_resp_mem_pkg::*;
#(
  parameter int unsigned WORD_WIDTH     = HSID_WORD_WIDTH,
  parameter int unsigned MEM_ADDR_WIDTH = 10,
  parameter int unsigned RSP_LATENCY    = 1,
  parameter int unsigned GNT_STALL      = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  hsid_x_obi_resp_mem_if.slave      obi,
  input  logic                      bd_we,
  input  logic [MEM_ADDR_WIDTH-1:0] bd_addr,
  input  logic [WORD_WIDTH-1:0]     bd_wdata,
  output logic                      addr_err,
  output logic [15:0]               err_count
);

  localparam int unsigned NUM_BE  = WORD_WIDTH / 8;
  localparam int unsigned DEPTH   = 2 ** MEM_ADDR_WIDTH;
  localparam int unsigned STALL_W = cnt_width(GNT_STALL);

  if (RSP_LATENCY < 1 || RSP_LATENCY > HSID_OBI_MAX_RSP_LATENCY) begin : g_bad_latency
    $error("hsid_x_obi_resp_mem: RSP_LATENCY must be 1..HSID_OBI_MAX_RSP_LATENCY");
  end
  if (WORD_WIDTH != HSID_WORD_WIDTH) begin : g_bad_width
    $error("hsid_x_obi_resp_mem: WORD_WIDTH must match the OBI struct data width");
  end
  if (MEM_ADDR_WIDTH < 1 || MEM_ADDR_WIDTH + 2 >= OBI_ADDR_WIDTH) begin : g_bad_aw
    $error("hsid_x_obi_resp_mem: MEM_ADDR_WIDTH does not fit the OBI byte address");
  end

  obi_req_t                  req;
  obi_resp_t                 rsp;
  logic                      accept;
  logic                      oor;
  logic [MEM_ADDR_WIDTH-1:0] widx;
  logic                      unused_addr_lsbs;

  logic [WORD_WIDTH-1:0]     mem_q [DEPTH];

  grant_state_e              state_q;
  logic                      gnt_q;
  logic [STALL_W-1:0]        stall_cnt_q;
  logic                      addr_err_q;
  logic [15:0]               err_cnt_q;

  logic                      pipe_valid_d;
  logic [WORD_WIDTH-1:0]     pipe_data_d;
  logic                      rsp_valid;
  logic [WORD_WIDTH-1:0]     rsp_data;

  assign req              = obi.obi_req;
  assign accept           = req.req & gnt_q;
  assign widx             = req.addr[MEM_ADDR_WIDTH+1:2];
  assign oor              = |req.addr[OBI_ADDR_WIDTH-1:MEM_ADDR_WIDTH+2];
  assign unused_addr_lsbs = ^req.addr[1:0];

  // Array has no reset. The OBI lane writes are issued after the backdoor
  // write so that, on a same-word collision, enabled OBI lanes win and the
  // backdoor value survives on the remaining lanes.
  always_ff @(posedge clk) begin
    if (bd_we) begin
      mem_q[bd_addr] <= bd_wdata;
    end
    if (accept && req.we && !oor) begin
      for (int unsigned i = 0; i < NUM_BE; i++) begin
        if (req.be[i]) begin
          mem_q[widx][8*i +: 8] <= req.wdata[8*i +: 8];
        end
      end
    end
  end

  // Read data is sampled from the pre-edge array contents, so a backdoor
  // write in the acceptance cycle is not visible to that read.
  always_comb begin
    pipe_valid_d = accept;
    pipe_data_d  = '0;
    if (accept && !req.we && !oor) begin
      pipe_data_d = mem_q[widx];
    end
  end

  // gnt_q is held low through reset even though the state is GRANT; it
  // rises on the first edge after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= GRANT;
      gnt_q       <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      case (state_q)
        GRANT: begin
          gnt_q <= 1'b1;
          if (accept && GNT_STALL != 0) begin
            state_q     <= STALL;
            stall_cnt_q <= STALL_W'(GNT_STALL);
            gnt_q       <= 1'b0;
          end
        end
        STALL: begin
          if (stall_cnt_q == STALL_W'(1)) begin
            state_q <= GRANT;
            gnt_q   <= 1'b1;
          end else begin
            stall_cnt_q <= stall_cnt_q - STALL_W'(1);
          end
        end
        default: begin
          state_q <= GRANT;
          gnt_q   <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_err_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      addr_err_q <= accept & oor;
      if (accept && oor && err_cnt_q != '1) begin
        err_cnt_q <= err_cnt_q + 16'd1;
      end
    end
  end

  hsid_x_obi_rsp_pipe #(
    .LATENCY (RSP_LATENCY),
    .WIDTH   (WORD_WIDTH)
  ) u_rsp_pipe (
    .clk     (clk),
    .rst     (rst),
    .valid_i (pipe_valid_d),
    .data_i  (pipe_data_d),
    .valid_o (rsp_valid),
    .data_o  (rsp_data)
  );

  always_comb begin
    rsp        = '0;
    rsp.gnt    = gnt_q;
    rsp.rvalid = rsp_valid;
    rsp.rdata  = rsp_data;
  end

  assign obi.obi_rsp = rsp;
  assign addr_err    = addr_err_q;
  assign err_count   = err_cnt_q;

endmodule

// File: tb/tb_hsid_x_obi_resp_mem.sv
// Bench for hsid_x_obi_resp_mem: three instances cover latency 1 / no stall,
// latency 2 / stall 2 and latency 4 / no stall.
module tb_hsid_x_obi_resp_mem;
  import hsid_x_obi_inf_pkg::*;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  obi_req_t    req_drv   [3];
  obi_resp_t   rsp_mon   [3];
  logic        bd_we     [3];
  logic [9:0]  bd_addr   [3];
  logic [31:0] bd_wdata  [3];
  logic        addr_err  [3];
  logic [15:0] err_count [3];

  hsid_x_obi_resp_mem_if if0 ();
  hsid_x_obi_resp_mem_if if1 ();
  hsid_x_obi_resp_mem_if if2 ();

  assign if0.obi_req = req_drv[0];
  assign if1.obi_req = req_drv[1];
  assign if2.obi_req = req_drv[2];
  assign rsp_mon[0]  = if0.obi_rsp;
  assign rsp_mon[1]  = if1.obi_rsp;
  assign rsp_mon[2]  = if2.obi_rsp;

  hsid_x_obi_resp_mem #(.WORD_WIDTH(32), .MEM_ADDR_WIDTH(10), .RSP_LATENCY(1), .GNT_STALL(0)) u_dut0 (
    .clk(clk), .rst(rst), .obi(if0), .bd_we(bd_we[0]), .bd_addr(bd_addr[0]),
    .bd_wdata(bd_wdata[0]), .addr_err(addr_err[0]), .err_count(err_count[0]));
  hsid_x_obi_resp_mem #(.WORD_WIDTH(32), .MEM_ADDR_WIDTH(10), .RSP_LATENCY(2), .GNT_STALL(2)) u_dut1 (
    .clk(clk), .rst(rst), .obi(if1), .bd_we(bd_we[1]), .bd_addr(bd_addr[1]),
    .bd_wdata(bd_wdata[1]), .addr_err(addr_err[1]), .err_count(err_count[1]));
  hsid_x_obi_resp_mem #(.WORD_WIDTH(32), .MEM_ADDR_WIDTH(10), .RSP_LATENCY(4), .GNT_STALL(0)) u_dut2 (
    .clk(clk), .rst(rst), .obi(if2), .bd_we(bd_we[2]), .bd_addr(bd_addr[2]),
    .bd_wdata(bd_wdata[2]), .addr_err(addr_err[2]), .err_count(err_count[2]));

  exp_t sbq0 [$];
  exp_t sbq1 [$];
  exp_t sbq2 [$];
  exp_t mon_e;

  function automatic int lat_of(input int k);
    case (k)
      0:       return 1;
      1:       return 2;
      default: return 4;
    endcase
  endfunction

  function automatic int qsize(input int k);
    case (k)
      0:       return sbq0.size();
      1:       return sbq1.size();
      default: return sbq2.size();
    endcase
  endfunction

  task automatic push_exp(input int k, input exp_t e);
    case (k)
      0:       sbq0.push_back(e);
      1:       sbq1.push_back(e);
      default: sbq2.push_back(e);
    endcase
  endtask

  task automatic pop_exp(input int k, output exp_t e);
    case (k)
      0:       e = sbq0.pop_front();
      1:       e = sbq1.pop_front();
      default: e = sbq2.pop_front();
    endcase
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every rvalid must match the oldest expected response of its
  // instance in both data and cycle.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rsp_mon[k].rvalid !== 1'b0) begin
        if (qsize(k) == 0) begin
          check($sformatf("spurious_rvalid_%0d", k), 32'(rsp_mon[k].rvalid), 32'd0);
        end else begin
          pop_exp(k, mon_e);
          check($sformatf("rdata_%0d", k), rsp_mon[k].rdata, mon_e.data);
          check($sformatf("rvalid_cycle_%0d", k), 32'(cyc), 32'(mon_e.due));
        end
      end
    end
  end

  task automatic bd_set(input int k, input logic [9:0] a, input logic [31:0] d);
    bd_we[k]    = 1'b1;
    bd_addr[k]  = a;
    bd_wdata[k] = d;
  endtask

  task automatic bd_clr(input int k);
    bd_we[k] = 1'b0;
  endtask

  task automatic bd_write(input int k, input logic [9:0] a, input logic [31:0] d);
    bd_set(k, a, d);
    @(negedge clk);
    bd_clr(k);
  endtask

  // Present a request from a negedge, wait for gnt, record the expected
  // response and return at the negedge following the accepting edge.
  task automatic issue(input int k, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd);
    int   w;
    exp_t e;
    w = 0;
    req_drv[k].req   = 1'b1;
    req_drv[k].we    = we;
    req_drv[k].be    = be;
    req_drv[k].addr  = addr;
    req_drv[k].wdata = wdata;
    while (rsp_mon[k].gnt !== 1'b1 && w < 16) begin
      @(negedge clk);
      w++;
    end
    if (w >= 16) begin
      check($sformatf("gnt_timeout_%0d", k), 32'(rsp_mon[k].gnt), 32'd1);
    end else begin
      e.data = exp_rd;
      e.due  = cyc + lat_of(k);
      push_exp(k, e);
    end
    @(negedge clk);
    req_drv[k].req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   acc;
    exp_t e;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_drv[k]  = '0;
      bd_we[k]    = 1'b0;
      bd_addr[k]  = '0;
      bd_wdata[k] = '0;
    end

    // Reset values
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_gnt_%0d", k), 32'(rsp_mon[k].gnt), 32'd0);
      check($sformatf("rst_rvalid_%0d", k), 32'(rsp_mon[k].rvalid), 32'd0);
      check($sformatf("rst_rdata_%0d", k), rsp_mon[k].rdata, 32'd0);
      check($sformatf("rst_addr_err_%0d", k), 32'(addr_err[k]), 32'd0);
      check($sformatf("rst_err_count_%0d", k), 32'(err_count[k]), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("gnt_after_rst_%0d", k), 32'(rsp_mon[k].gnt), 32'd1);
    end

    // Byte-enable write, then be=0 write leaves the word alone
    bd_write(0, 10'd3, 32'h1122_3344);
    issue(0, 1'b1, 4'b0101, 32'h0000_000C, 32'hAABB_CCDD, 32'h0);
    check("addr_err_inrange", 32'(addr_err[0]), 32'd0);
    issue(0, 1'b0, 4'b1111, 32'h0000_000C, 32'h0, 32'h11BB_33DD);
    issue(0, 1'b1, 4'b0000, 32'h0000_000C, 32'hFFFF_FFFF, 32'h0);
    issue(0, 1'b0, 4'b1111, 32'h0000_000C, 32'h0, 32'h11BB_33DD);

    // Out-of-range: read returns 0, write dropped, two error pulses
    bd_write(0, 10'd1, 32'h0101_0101);
    issue(0, 1'b0, 4'b1111, 32'h0000_1000, 32'h0, 32'h0);
    check("addr_err_oor_rd", 32'(addr_err[0]), 32'd1);
    check("err_count_1", 32'(err_count[0]), 32'd1);
    issue(0, 1'b1, 4'b1111, 32'h0000_1004, 32'hFFFF_FFFF, 32'h0);
    check("addr_err_oor_wr", 32'(addr_err[0]), 32'd1);
    check("err_count_2", 32'(err_count[0]), 32'd2);
    @(negedge clk);
    check("addr_err_cleared", 32'(addr_err[0]), 32'd0);
    issue(0, 1'b0, 4'b1111, 32'h0000_0004, 32'h0, 32'h0101_0101);

    // Back-to-back write then read of the same word
    issue(0, 1'b1, 4'b1111, 32'h0000_001C, 32'hCAFE_F00D, 32'h0);
    issue(0, 1'b0, 4'b1111, 32'h0000_001C, 32'h0, 32'hCAFE_F00D);

    // Same-cycle OBI/backdoor collision, full and partial lanes
    bd_set(0, 10'd9, 32'h0);
    issue(0, 1'b1, 4'b1111, 32'h0000_0024, 32'h1234_5678, 32'h0);
    bd_clr(0);
    issue(0, 1'b0, 4'b1111, 32'h0000_0024, 32'h0, 32'h1234_5678);
    bd_set(0, 10'd11, 32'h1111_2222);
    issue(0, 1'b1, 4'b0011, 32'h0000_002C, 32'hAAAA_BBBB, 32'h0);
    bd_clr(0);
    issue(0, 1'b0, 4'b1111, 32'h0000_002C, 32'h0, 32'h1111_BBBB);

    // Read sees the array before a same-cycle backdoor write
    bd_write(0, 10'd10, 32'h0A0A_0A0A);
    bd_set(0, 10'd10, 32'hFFFF_FFFF);
    issue(0, 1'b0, 4'b1111, 32'h0000_0028, 32'h0, 32'h0A0A_0A0A);
    bd_clr(0);
    issue(0, 1'b0, 4'b1111, 32'h0000_0028, 32'h0, 32'hFFFF_FFFF);
    repeat (6) @(negedge clk);

    // Preload and read with latency 2
    bd_write(1, 10'd5, 32'hDEAD_BEEF);
    bd_write(1, 10'd0, 32'h0000_00A0);
    bd_write(1, 10'd1, 32'h0000_00A1);
    bd_write(1, 10'd2, 32'h0000_00A2);
    issue(1, 1'b0, 4'b1111, 32'h0000_0014, 32'h0, 32'hDEAD_BEEF);
    repeat (4) @(negedge clk);

    // Grant throttling with req held for 9 cycles
    acc = 0;
    for (int i = 0; i < 9; i++) begin
      req_drv[1].req  = 1'b1;
      req_drv[1].we   = 1'b0;
      req_drv[1].be   = 4'b1111;
      req_drv[1].addr = 32'(acc) << 2;
      check($sformatf("gnt_pattern_%0d", i), 32'(rsp_mon[1].gnt), 32'((i % 3) == 0));
      if (rsp_mon[1].gnt === 1'b1) begin
        e.data = 32'h0000_00A0 + 32'(acc);
        e.due  = cyc + lat_of(1);
        push_exp(1, e);
        acc++;
      end
      @(negedge clk);
    end
    req_drv[1].req = 1'b0;
    check("throttle_accepts", 32'(acc), 32'd3);
    repeat (6) @(negedge clk);

    // Reset flush with latency 4
    bd_write(2, 10'd0, 32'h0000_0077);
    issue(2, 1'b0, 4'b1111, 32'h0000_0000, 32'h0, 32'h0000_0077);
    issue(2, 1'b0, 4'b1111, 32'h0000_0004, 32'h0, 32'h0);
    rst = 1'b1;
    sbq0.delete();
    sbq1.delete();
    sbq2.delete();
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("gnt_in_rst_%0d", k), 32'(rsp_mon[k].gnt), 32'd0);
    end
    check("err_count_cleared", 32'(err_count[0]), 32'd0);
    @(negedge clk);
    check("gnt_in_rst_late", 32'(rsp_mon[2].gnt), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("gnt_after_flush", 32'(rsp_mon[2].gnt), 32'd1);
    repeat (8) @(negedge clk);

    for (int k = 0; k < 3; k++) begin
      check($sformatf("pending_left_%0d", k), 32'(qsize(k)), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
